// File: rtl/fetch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared definitions for the MIPS fetch run-control sequencer:
//   - state_e   : sequencer FSM state encodings (also exported on o_state)
//   - cmd_e     : debug/loader front-end command codes
//   - pc_sel_e  : next-PC source select codes for instruction_fetch
//   - HALT_OPCODE : instruction word that terminates a load and stops execution
//   - clogb2()  : ceiling log2 for sizing counters from parameters
// ---------------------------------------------------------------------------
package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StRun  = 3'd2,
        StStep = 3'd3,
        StHalt = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CmdNone = 2'b00,
        CmdLoad = 2'b01,
        CmdRun  = 2'b10,
        CmdStep = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        PcSelPc4     = 2'b00,
        PcSelBranch  = 2'b01,
        PcSelJumpInm = 2'b10,
        PcSelJumpRs  = 2'b11
    } pc_sel_e;

    localparam logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF;

    // Ceiling log2; clogb2(1) = 0, clogb2(4) = 2, clogb2(2048) = 11.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// ---------------------------------------------------------------------------
// loader_word_assembler
// Packs a byte-serial loader stream into instruction words, big-endian
// (first byte lands in the most significant byte).
//
// Ports:
//   i_clock       system clock
//   i_clear       synchronous clear: drops any partial word and the ready pulse
//   i_byte        loader data byte
//   i_byte_valid  i_byte qualifier (already gated to the LOAD state by the caller)
//   o_word        assembled word, stable while o_word_valid is high
//   o_word_valid  one-cycle pulse, the cycle after the final byte of a word
// ---------------------------------------------------------------------------
module loader_word_assembler
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned NB_INSTR = 32,
    parameter int unsigned NB_BYTE  = 8
) (
    input  logic                i_clock,
    input  logic                i_clear,
    input  logic [NB_BYTE-1:0]  i_byte,
    input  logic                i_byte_valid,
    output logic [NB_INSTR-1:0] o_word,
    output logic                o_word_valid
);

    localparam int unsigned N_BYTES = NB_INSTR / NB_BYTE;
    localparam int unsigned NB_IDX  = (clogb2(N_BYTES) > 0) ? clogb2(N_BYTES) : 1;

    logic [NB_INSTR-1:0] r_shift;
    logic [NB_IDX-1:0]   r_byte_idx;
    logic                r_word_valid;
    logic                w_last_byte;

    assign w_last_byte = (r_byte_idx == NB_IDX'(N_BYTES - 1));

    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_shift      <= '0;
            r_byte_idx   <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_byte_valid) begin
                // Shifting left leaves the first byte of the word on top.
                r_shift <= {r_shift[NB_INSTR-NB_BYTE-1:0], i_byte};
                if (w_last_byte) begin
                    r_byte_idx   <= '0;
                    r_word_valid <= 1'b1;
                end else begin
                    r_byte_idx <= r_byte_idx + 1'b1;
                end
            end
        end
    end

    assign o_word       = r_shift;
    assign o_word_valid = r_word_valid;

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Run-control sequencer for the MIPS instruction fetch stage: loads
// instruction memory from a byte stream, gates the fetch enable for free-run
// and single-step execution, and resolves redirect priority.
//
// Ports:
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_cmd, i_cmd_valid      command (00 none, 01 load, 10 run, 11 step), 1-cycle pulse
//   i_byte, i_byte_valid    loader byte stream, honoured only in LOAD
//   i_stall                 hazard-unit stall
//   i_halt_detected         decode saw the HALT opcode
//   i_jump_rs, i_jump_inm,
//   i_branch                redirect requests
//   o_imem_wr_en/addr/data  instruction memory write port
//   o_valid                 fetch-stage enable (instruction_fetch i_valid)
//   o_pc_sel                next-PC source: 00 pc+4, 01 branch, 10 jump_inm, 11 jump_rs
//   o_flush                 squash the instruction already fetched
//   o_state                 current FSM state (debug)
//   o_load_count            words written by the last completed load
// ---------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned NB_INSTR           = 32,
    parameter int unsigned N_ADDR             = 2048,
    parameter int unsigned LOG2_N_INSMEM_ADDR = 11,
    parameter int unsigned NB_BYTE            = 8
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic [1:0]                    i_cmd,
    input  logic                          i_cmd_valid,
    input  logic [NB_BYTE-1:0]            i_byte,
    input  logic                          i_byte_valid,
    input  logic                          i_stall,
    input  logic                          i_halt_detected,
    input  logic                          i_jump_rs,
    input  logic                          i_jump_inm,
    input  logic                          i_branch,
    output logic                          o_imem_wr_en,
    output logic [LOG2_N_INSMEM_ADDR-1:0] o_imem_addr,
    output logic [NB_INSTR-1:0]           o_imem_data,
    output logic                          o_valid,
    output logic [1:0]                    o_pc_sel,
    output logic                          o_flush,
    output logic [2:0]                    o_state,
    output logic [LOG2_N_INSMEM_ADDR:0]   o_load_count
);

    state_e                        r_state;
    logic [LOG2_N_INSMEM_ADDR-1:0] r_word_cnt;
    logic [LOG2_N_INSMEM_ADDR:0]   r_load_count;
    logic                          r_step_pending;

    logic                          w_cmd_load;
    logic                          w_cmd_run;
    logic                          w_cmd_step;
    logic                          w_enter_load;
    logic                          w_asm_clear;
    logic                          w_asm_byte_valid;
    logic [NB_INSTR-1:0]           w_word;
    logic                          w_word_valid;
    logic                          w_wr_en;
    logic                          w_last_word;
    logic [LOG2_N_INSMEM_ADDR:0]   w_cnt_plus1;
    logic                          w_step_fire;
    logic                          w_valid;
    pc_sel_e                       w_pc_sel;

    assign w_cmd_load = i_cmd_valid && (cmd_e'(i_cmd) == CmdLoad);
    assign w_cmd_run  = i_cmd_valid && (cmd_e'(i_cmd) == CmdRun);
    assign w_cmd_step = i_cmd_valid && (cmd_e'(i_cmd) == CmdStep);

    // Load is accepted only from IDLE and HALT; the assembler restarts on entry
    // so a word left half-built by an earlier stream can never leak through.
    assign w_enter_load     = w_cmd_load && ((r_state == StIdle) || (r_state == StHalt));
    assign w_asm_clear      = i_reset || w_enter_load;
    assign w_asm_byte_valid = i_byte_valid && (r_state == StLoad);

    loader_word_assembler #(
        .NB_INSTR (NB_INSTR),
        .NB_BYTE  (NB_BYTE)
    ) u_loader_word_assembler (
        .i_clock      (i_clock),
        .i_clear      (w_asm_clear),
        .i_byte       (i_byte),
        .i_byte_valid (w_asm_byte_valid),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    assign w_wr_en     = w_word_valid && (r_state == StLoad);
    assign w_cnt_plus1 = {1'b0, r_word_cnt} + (LOG2_N_INSMEM_ADDR + 1)'(1);
    // Stop on HALT or on the top word; the counter never wraps back to 0.
    assign w_last_word = (w_word == HALT_OPCODE)
                      || (r_word_cnt == LOG2_N_INSMEM_ADDR'(N_ADDR - 1));

    assign w_step_fire = (r_state == StStep) && r_step_pending && !i_stall;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= StIdle;
            r_word_cnt     <= '0;
            r_load_count   <= '0;
            r_step_pending <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_cmd_load) begin
                        r_state    <= StLoad;
                        r_word_cnt <= '0;
                    end else if (w_cmd_run) begin
                        r_state <= StRun;
                    end else if (w_cmd_step) begin
                        r_state        <= StStep;
                        r_step_pending <= 1'b1;
                    end
                end
                StLoad: begin
                    if (w_wr_en) begin
                        if (w_last_word) begin
                            r_state      <= StIdle;
                            r_load_count <= w_cnt_plus1;
                        end else begin
                            r_word_cnt <= w_cnt_plus1[LOG2_N_INSMEM_ADDR-1:0];
                        end
                    end
                end
                StRun: begin
                    if (i_halt_detected) begin
                        r_state <= StHalt;
                    end else if (w_cmd_step) begin
                        r_state        <= StStep;
                        r_step_pending <= 1'b1;
                    end
                end
                StStep: begin
                    if (i_halt_detected) begin
                        r_state        <= StHalt;
                        r_step_pending <= 1'b0;
                    end else if (w_cmd_run) begin
                        r_state        <= StRun;
                        r_step_pending <= 1'b0;
                    end else if (w_cmd_step) begin
                        // Sets a fresh request, or leaves an unfired one alone
                        // (the extra step is dropped).
                        r_step_pending <= 1'b1;
                    end else if (w_step_fire) begin
                        r_step_pending <= 1'b0;
                    end
                end
                StHalt: begin
                    if (w_cmd_load) begin
                        r_state    <= StLoad;
                        r_word_cnt <= '0;
                    end
                end
                default: begin
                    r_state        <= StIdle;
                    r_step_pending <= 1'b0;
                end
            endcase
        end
    end

    // Fetch enable must react to the stall in the same cycle, so it is decoded
    // from the registered state rather than registered itself.
    always_comb begin
        w_valid = 1'b0;
        unique case (r_state)
            StRun:   w_valid = !i_stall;
            StStep:  w_valid = w_step_fire;
            default: w_valid = 1'b0;
        endcase
    end

    always_comb begin
        w_pc_sel = PcSelPc4;
        if (i_jump_rs) begin
            w_pc_sel = PcSelJumpRs;
        end else if (i_jump_inm) begin
            w_pc_sel = PcSelJumpInm;
        end else if (i_branch) begin
            w_pc_sel = PcSelBranch;
        end
    end

    assign o_imem_wr_en = w_wr_en;
    assign o_imem_addr  = r_word_cnt;
    assign o_imem_data  = w_word;
    assign o_valid      = w_valid;
    assign o_pc_sel     = w_pc_sel;
    assign o_flush      = w_valid && (i_jump_rs || i_jump_inm || i_branch);
    assign o_state      = r_state;
    assign o_load_count = r_load_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk;
    logic        i_reset;
    logic [1:0]  i_cmd;
    logic        i_cmd_valid;
    logic [7:0]  i_byte;
    logic        i_byte_valid;
    logic        i_stall;
    logic        i_halt_detected;
    logic        i_jump_rs;
    logic        i_jump_inm;
    logic        i_branch;
    logic        o_imem_wr_en;
    logic [10:0] o_imem_addr;
    logic [31:0] o_imem_data;
    logic        o_valid;
    logic [1:0]  o_pc_sel;
    logic        o_flush;
    logic [2:0]  o_state;
    logic [11:0] o_load_count;

    fetch_sequencer #(
        .NB_INSTR           (32),
        .N_ADDR             (2048),
        .LOG2_N_INSMEM_ADDR (11),
        .NB_BYTE            (8)
    ) dut (
        .i_clock         (clk),
        .i_reset         (i_reset),
        .i_cmd           (i_cmd),
        .i_cmd_valid     (i_cmd_valid),
        .i_byte          (i_byte),
        .i_byte_valid    (i_byte_valid),
        .i_stall         (i_stall),
        .i_halt_detected (i_halt_detected),
        .i_jump_rs       (i_jump_rs),
        .i_jump_inm      (i_jump_inm),
        .i_branch        (i_branch),
        .o_imem_wr_en    (o_imem_wr_en),
        .o_imem_addr     (o_imem_addr),
        .o_imem_data     (o_imem_data),
        .o_valid         (o_valid),
        .o_pc_sel        (o_pc_sel),
        .o_flush         (o_flush),
        .o_state         (o_state),
        .o_load_count    (o_load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  writes_seen = 0;
    int  writes_pushed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [10:0] addr, input logic [31:0] data);
        exp_q.push_back('{addr: addr, data: data});
        writes_pushed++;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            i_byte       = w[8*i +: 8];
            i_byte_valid = 1'b1;
            next();
        end
    endtask

    task automatic issue_cmd(input logic [1:0] c);
        i_cmd       = c;
        i_cmd_valid = 1'b1;
        next();
        i_cmd_valid = 1'b0;
        i_cmd       = 2'b00;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        next();
        next();
        i_reset = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int n;
        n = 0;
        @(negedge clk);
        while (o_state != 3'd0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        chk(name, {29'd0, o_state}, 32'd0);
        next();
    endtask

    // Scoreboard monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (o_imem_wr_en) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %h@%0d expected no write",
                         o_imem_data, o_imem_addr);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", {21'd0, o_imem_addr}, {21'd0, e.addr});
                chk("write_data", o_imem_data, e.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    int pulses;

    initial begin
        i_reset = 1'b1; i_cmd = 2'b00; i_cmd_valid = 1'b0; i_byte = 8'h00;
        i_byte_valid = 1'b0; i_stall = 1'b0; i_halt_detected = 1'b0;
        i_jump_rs = 1'b0; i_jump_inm = 1'b0; i_branch = 1'b0;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_state", {29'd0, o_state}, 32'd0);
        chk("rst_load_count", {20'd0, o_load_count}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_wr_en", {31'd0, o_imem_wr_en}, 32'd0);
        next();

        // Small load terminated by HALT
        expect_write(11'd0, 32'h8C01_0004);
        expect_write(11'd1, 32'h0000_0000);
        expect_write(11'd2, 32'hFFFF_FFFF);
        issue_cmd(2'b01);
        send_word(32'h8C01_0004);
        send_word(32'h0000_0000);
        send_word(32'hFFFF_FFFF);
        i_byte_valid = 1'b0;
        wait_idle("load1_idle", 20);
        @(negedge clk);
        chk("load1_count", {20'd0, o_load_count}, 32'd3);
        next();

        // Free run with stall and halt
        issue_cmd(2'b10);
        for (int c = 1; c <= 8; c++) begin
            i_stall         = (c == 3 || c == 4);
            i_halt_detected = (c == 6);
            @(negedge clk);
            chk($sformatf("run_valid_c%0d", c), {31'd0, o_valid},
                (c <= 6 && c != 3 && c != 4) ? 32'd1 : 32'd0);
            chk($sformatf("run_state_c%0d", c), {29'd0, o_state},
                (c <= 6) ? 32'd2 : 32'd4);
            next();
        end
        i_stall = 1'b0; i_halt_detected = 1'b0;
        // HALT ignores run and step
        issue_cmd(2'b11);
        issue_cmd(2'b10);
        @(negedge clk);
        chk("halt_ignores_cmds", {29'd0, o_state}, 32'd4);
        chk("halt_valid", {31'd0, o_valid}, 32'd0);
        next();

        // Single step
        do_reset();
        pulses = 0;
        for (int c = 0; c <= 24; c++) begin
            i_cmd           = 2'b11;
            i_cmd_valid     = (c == 0 || c == 5 || c == 10 || c == 15 || c == 16 || c == 21);
            i_stall         = (c == 5 || c == 6 || c == 15 || c == 16 || c == 17);
            i_halt_detected = (c == 21);
            @(negedge clk);
            if (o_valid) pulses++;
            chk($sformatf("step_valid_c%0d", c), {31'd0, o_valid},
                (c == 1 || c == 7 || c == 11 || c == 18) ? 32'd1 : 32'd0);
            chk($sformatf("step_state_c%0d", c), {29'd0, o_state},
                (c == 0) ? 32'd0 : (c <= 21) ? 32'd3 : 32'd4);
            next();
        end
        i_cmd_valid = 1'b0; i_cmd = 2'b00; i_stall = 1'b0; i_halt_detected = 1'b0;
        chk("step_pulse_count", pulses, 32'd4);

        // Redirect priority
        do_reset();
        i_branch = 1'b1;
        @(negedge clk);
        chk("idle_pc_sel", {30'd0, o_pc_sel}, 32'd1);
        chk("idle_flush", {31'd0, o_flush}, 32'd0);
        next();
        i_branch = 1'b0;
        issue_cmd(2'b10);
        for (int c = 0; c < 4; c++) begin
            i_jump_rs  = (c == 0);
            i_jump_inm = (c <= 1);
            i_branch   = (c <= 2);
            @(negedge clk);
            chk($sformatf("redir_pc_sel_%0d", c), {30'd0, o_pc_sel}, 32'd3 - c);
            chk($sformatf("redir_flush_%0d", c), {31'd0, o_flush}, (c < 3) ? 32'd1 : 32'd0);
            next();
        end
        i_jump_rs = 1'b0; i_jump_inm = 1'b0; i_branch = 1'b0;

        // Full-depth load, extra bytes must be ignored afterwards
        do_reset();
        issue_cmd(2'b01);
        for (int i = 0; i < 2048; i++) begin
            expect_write(11'(i), 32'h5A00_0000 | i);
            send_word(32'h5A00_0000 | i);
        end
        send_word(32'h1111_2222);
        i_byte_valid = 1'b0;
        wait_idle("full_idle", 20);
        @(negedge clk);
        chk("full_count", {20'd0, o_load_count}, 32'd2048);
        next();
        repeat (4) next();
        chk("full_writes", writes_seen, writes_pushed);

        // Reset in the middle of a load
        issue_cmd(2'b01);
        i_byte = 8'hAA; i_byte_valid = 1'b1; next();
        i_byte = 8'hBB; next();
        i_byte_valid = 1'b0;
        do_reset();
        @(negedge clk);
        chk("midrst_state", {29'd0, o_state}, 32'd0);
        next();
        expect_write(11'd0, 32'h1234_5678);
        issue_cmd(2'b01);
        send_word(32'h1234_5678);
        i_byte_valid = 1'b0;
        repeat (4) next();

        chk("total_writes", writes_seen, writes_pushed);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
